// File: rtl/vec_gen.sv
// Valid/ready test-vector generator: INC / LFSR / WALK1 / ALT patterns,
// programmable burst length (0 = continuous), abort via run deassertion.
module vec_gen #(
    parameter int              WIDTH = 8,
    parameter int              LEN_W = 8,
    parameter logic [WIDTH-1:0] SEED = 'h01,
    parameter logic [WIDTH-1:0] TAPS = 'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic             vec_ready,
    output logic             vec_valid,
    output logic [WIDTH-1:0] vector,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [1:0] M_INC = 2'd0, M_LFSR = 2'd1, M_WALK = 2'd2, M_ALT = 2'd3;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   vector_q, vector_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic               last;
    logic [LEN_W-1:0]   cnt_inc;

    function automatic logic [WIDTH-1:0] first_pat(input logic [1:0] m);
        logic [WIDTH-1:0] r;
        r = '0;
        case (m)
            M_INC:   r = '0;
            M_LFSR:  r = (SEED == '0) ? WIDTH'(1) : SEED;
            M_WALK:  r = WIDTH'(1);
            default: for (int i = 0; i < WIDTH; i++) r[i] = (i % 2 == 0);
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] next_pat(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (m)
            M_INC:   r = v + WIDTH'(1);
            M_LFSR:  r = {v[WIDTH-2:0], ^(v & TAPS)};
            M_WALK:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = ~v;
        endcase
        return r;
    endfunction

    assign xfer    = valid_q && vec_ready;
    assign cnt_inc = cnt_q + LEN_W'(1);
    // A zero latched length means continuous: the counter wraps and never completes.
    assign last    = (len_q != '0) && (cnt_inc == len_q);

    always_comb begin
        state_d  = state_q;
        run_d    = run;
        mode_d   = mode_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run && !run_q) begin
                    mode_d   = mode;
                    len_d    = len;
                    cnt_d    = '0;
                    vector_d = first_pat(mode);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = GEN;
                end
            end
            GEN, DRAIN: begin
                if (xfer) begin
                    cnt_d    = cnt_inc;
                    vector_d = next_pat(mode_q, vector_q);
                    // Final beat completes even if run dropped on the same edge.
                    if (last || !run || state_q == DRAIN) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = last;
                        state_d = IDLE;
                    end
                end else if (!run) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            mode_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            vector_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign vec_valid = valid_q;
    assign vector    = vector_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vec_gen.sv
// Directed bench for vec_gen: cycle table for short bursts/aborts, hand-written
// sequences for LFSR period, WALK1 with back-pressure and reset mid-burst.
module tb_vec_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic [7:0] len;
    logic       vec_ready;
    logic       vec_valid;
    logic [7:0] vector;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    vec_gen #(.WIDTH(8), .LEN_W(8), .SEED(8'h01), .TAPS(8'hB8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .len(len),
        .vec_ready(vec_ready), .vec_valid(vec_valid), .vector(vector),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [1:0] mode;
        logic [7:0] len;
        logic       ready;
        logic       e_valid;
        logic       chk_vec;
        logic [7:0] e_vec;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic rn, input logic [1:0] m, input logic [7:0] l,
                       input logic rd, input logic ev, input logic cv, input logic [7:0] evec,
                       input logic eb, input logic ed);
        vec_t t;
        t.rst_n = r; t.run = rn; t.mode = m; t.len = l; t.ready = rd;
        t.e_valid = ev; t.chk_vec = cv; t.e_vec = evec; t.e_busy = eb; t.e_done = ed;
        tbl.push_back(t);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    initial begin
        logic [7:0] exp_v;
        logic [255:0] seen;
        int distinct;
        int acc;
        bit done_seen;

        rst_n = 1'b0; run = 1'b0; mode = 2'd0; len = 8'd0; vec_ready = 1'b0;

        // rst run mode len rdy | valid chkvec vec busy done
        add(0, 0, 0, 4, 1,  0, 1, 8'h00, 0, 0);   // reset state
        // Test 1: INC len=4
        add(1, 1, 0, 4, 1,  1, 1, 8'h00, 1, 0);
        add(1, 1, 0, 4, 1,  1, 1, 8'h01, 1, 0);
        add(1, 1, 0, 4, 1,  1, 1, 8'h02, 1, 0);
        add(1, 1, 0, 4, 1,  1, 1, 8'h03, 1, 0);
        add(1, 1, 0, 4, 1,  0, 0, 8'h00, 0, 1);   // completion pulse
        add(1, 1, 0, 4, 1,  0, 0, 8'h00, 0, 0);   // run held: no restart
        add(1, 0, 0, 4, 1,  0, 0, 8'h00, 0, 0);
        // Test 4: ALT len=3, mode changed after start
        add(1, 1, 3, 3, 1,  1, 1, 8'h55, 1, 0);
        add(1, 1, 0, 3, 1,  1, 1, 8'hAA, 1, 0);
        add(1, 1, 0, 3, 1,  1, 1, 8'h55, 1, 0);
        add(1, 1, 0, 3, 1,  0, 0, 8'h00, 0, 1);
        add(1, 1, 0, 3, 1,  0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 3, 1,  0, 0, 8'h00, 0, 0);
        // Test 5: abort with back-pressure, drain holds beat
        add(1, 1, 0, 5, 0,  1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 5, 0,  1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 5, 0,  1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 5, 1,  0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 5, 1,  0, 0, 8'h00, 0, 0);
        // Abort and transfer on same edge -> straight to idle
        add(1, 1, 0, 0, 1,  1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 0, 1,  0, 0, 8'h00, 0, 0);
        // Abort on the final beat: completion wins
        add(1, 1, 0, 2, 1,  1, 1, 8'h00, 1, 0);
        add(1, 1, 0, 2, 1,  1, 1, 8'h01, 1, 0);
        add(1, 0, 0, 2, 1,  0, 0, 8'h00, 0, 1);
        add(1, 0, 0, 2, 1,  0, 0, 8'h00, 0, 0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; run = tbl[i].run; mode = tbl[i].mode;
            len = tbl[i].len; vec_ready = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d valid", i), 32'(vec_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d done", i), 32'(done), 32'(tbl[i].e_done));
            if (tbl[i].chk_vec)
                chk($sformatf("tbl%0d vector", i), 32'(vector), 32'(tbl[i].e_vec));
        end

        // Test 2: LFSR continuous, 256 beats
        run = 1'b1; mode = 2'd1; len = 8'd0; vec_ready = 1'b1;
        seen = '0; distinct = 0; done_seen = 0; exp_v = 8'h01;
        for (int b = 1; b <= 256; b++) begin
            step();
            if (b == 1 || b == 256 || vector !== exp_v)
                chk($sformatf("lfsr beat%0d", b), 32'(vector), 32'(exp_v));
            if (vector == 8'h00) chk("lfsr zero", 32'(vector), 32'h1);
            if (b <= 255 && !seen[vector]) begin
                seen[vector] = 1'b1;
                distinct++;
            end
            if (done) done_seen = 1;
            exp_v = lfsr_next(exp_v);
        end
        chk("lfsr distinct", 32'(distinct), 32'd255);
        chk("lfsr valid", 32'(vec_valid), 32'd1);
        chk("lfsr no done", 32'(done_seen), 32'd0);
        run = 1'b0;
        step();
        chk("lfsr stop", 32'(busy), 32'd0);

        // Test 3: WALK1 len=10 with ready toggling 1,0,1,0...
        run = 1'b1; mode = 2'd2; len = 8'd10; vec_ready = 1'b0;
        step();
        exp_v = 8'h01; acc = 0;
        chk("walk first", 32'(vector), 32'(exp_v));
        for (int c = 0; c < 40 && acc < 10; c++) begin
            vec_ready = (c % 2 == 0);
            step();
            if (vec_ready) begin
                acc++;
                exp_v = {exp_v[6:0], exp_v[7]};
                if (acc == 10) begin
                    chk("walk done", 32'(done), 32'd1);
                    chk("walk end valid", 32'(vec_valid), 32'd0);
                end else begin
                    chk($sformatf("walk acc%0d", acc), 32'(vector), 32'(exp_v));
                    chk("walk no done", 32'(done), 32'd0);
                end
            end else begin
                chk($sformatf("walk hold c%0d", c), 32'(vector), 32'(exp_v));
            end
        end
        chk("walk accepted", 32'(acc), 32'd10);
        run = 1'b0; vec_ready = 1'b0;
        step();

        // Test 6: reset mid-burst with run held high
        run = 1'b1; mode = 2'd0; len = 8'd8; vec_ready = 1'b1;
        step();
        chk("rst first", 32'(vector), 32'h00);
        step(); step(); step();
        chk("rst beat3", 32'(vector), 32'h03);
        rst_n = 1'b0;
        step();
        chk("rst vector", 32'(vector), 32'h00);
        chk("rst valid", 32'(vec_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("restart valid", 32'(vec_valid), 32'd1);
        chk("restart vector", 32'(vector), 32'h00);
        step();
        chk("restart next", 32'(vector), 32'h01);
        run = 1'b0;
        step();
        chk("restart abort", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
